spi_reg_cmd_parser: RTL

Consumes the byte stream leaving the RX synchronous FIFO with ready/valid handshaking, decodes host command frames, and drives a simple single-cycle register bus. Read results are emitted as a ready/valid byte stream toward the TX FIFO feeding the SPI slave. It sits between the RX FIFO output and the register file, and between the register file and the TX FIFO input.

---
 rtl/spi_reg_cmd_parser_pkg.sv | 41 ++++
 rtl/spi_reg_cmd_parser.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/spi_reg_cmd_parser_pkg.sv
// rtl/spi_reg_cmd_parser_pkg.sv - shared types and constants for the SPI register command parser
package spi_reg_cmd_parser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_LEN      = 3'd2,
    ST_WDATA    = 3'd3,
    ST_RD_ISSUE = 3'd4,
    ST_RD_WAIT  = 3'd5,
    ST_RD_PUSH  = 3'd6
  } state_t;

  // Frame fields in wire order
  typedef enum logic [1:0] {
    FIELD_OP   = 2'd0,
    FIELD_ADDR = 2'd1,
    FIELD_LEN  = 2'd2,
    FIELD_DATA = 2'd3
  } field_t;

  localparam logic [7:0] DEF_CMD_NOP   = 8'h00;
  localparam logic [7:0] DEF_CMD_WRITE = 8'h01;
  localparam logic [7:0] DEF_CMD_READ  = 8'h02;

  // Which frame field the parser expects next in a given state
  function automatic field_t state_field(input state_t s);
    case (s)
      ST_IDLE: return FIELD_OP;
      ST_ADDR: return FIELD_ADDR;
      ST_LEN:  return FIELD_LEN;
      default: return FIELD_DATA;
    endcase
  endfunction

  // States that pull bytes from the RX stream
  function automatic logic state_accepts_rx(input state_t s);
    return (s == ST_IDLE) || (s == ST_ADDR) || (s == ST_LEN) || (s == ST_WDATA);
  endfunction

endpackage

// File: rtl/spi_reg_cmd_parser.sv
// rtl/spi_reg_cmd_parser.sv - decodes host command frames into register bus writes/reads and streams read data out
module spi_reg_cmd_parser
  import spi_reg_cmd_parser_pkg::*;
#(
  parameter int unsigned ADDR_BYTES = 1,
  parameter logic [7:0]  CMD_WRITE  = DEF_CMD_WRITE,
  parameter logic [7:0]  CMD_READ   = DEF_CMD_READ,
  parameter logic [7:0]  CMD_NOP    = DEF_CMD_NOP
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    abort,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [8*ADDR_BYTES-1:0] bus_addr,
  output logic [7:0]              bus_wdata,
  output logic                    bus_we,
  output logic                    bus_re,
  input  logic [7:0]              bus_rdata,
  output logic                    busy,
  output logic                    err_cmd
);

  localparam int unsigned AW = 8 * ADDR_BYTES;
  localparam logic [1:0] LAST_ADDR_IDX = 2'(ADDR_BYTES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr;
  logic [7:0]    len;
  logic [1:0]    addr_idx;
  logic          is_read;
  logic          rx_fire;
  logic          tx_fire;
  logic          op_known;

  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;
  assign op_known = (rx_data == CMD_WRITE) || (rx_data == CMD_READ) || (rx_data == CMD_NOP);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort overrides every transition
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (rx_fire && ((rx_data == CMD_WRITE) || (rx_data == CMD_READ))) begin
          state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (rx_fire && (addr_idx == LAST_ADDR_IDX)) begin
          state_nxt = ST_LEN;
        end
      end
      ST_LEN: begin
        if (rx_fire) begin
          if (rx_data == 8'd0) begin
            state_nxt = ST_IDLE;
          end else if (is_read) begin
            state_nxt = ST_RD_ISSUE;
          end else begin
            state_nxt = ST_WDATA;
          end
        end
      end
      ST_WDATA: begin
        if (rx_fire && (len == 8'd1)) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RD_ISSUE: state_nxt = ST_RD_WAIT;
      ST_RD_WAIT:  state_nxt = ST_RD_PUSH;
      ST_RD_PUSH: begin
        if (tx_fire) begin
          state_nxt = (len == 8'd1) ? ST_IDLE : ST_RD_ISSUE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
    end
  end

  // Outputs decoded directly from state; busy also covers a write strobe still in flight
  always_comb begin
    rx_ready = 1'b0;
    bus_re   = 1'b0;
    busy     = 1'b0;
    rx_ready = state_accepts_rx(state) && !abort && !rst;
    bus_re   = (state == ST_RD_ISSUE);
    busy     = (state != ST_IDLE) || bus_we;
  end

  // Frame datapath: address/length tracking, write strobe, read capture and TX holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      len       <= 8'd0;
      addr_idx  <= 2'd0;
      is_read   <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= 8'd0;
      bus_we    <= 1'b0;
      tx_data   <= 8'd0;
      tx_valid  <= 1'b0;
      err_cmd   <= 1'b0;
    end else begin
      bus_we  <= 1'b0;
      err_cmd <= 1'b0;
      if (abort) begin
        tx_valid <= 1'b0;
        addr_idx <= 2'd0;
        len      <= 8'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rx_fire) begin
              addr_idx <= 2'd0;
              is_read  <= (rx_data == CMD_READ);
              err_cmd  <= !op_known;
            end
          end
          ST_ADDR: begin
            if (rx_fire) begin
              addr     <= AW'({addr, rx_data});
              addr_idx <= addr_idx + 2'd1;
            end
          end
          ST_LEN: begin
            if (rx_fire) begin
              len <= rx_data;
              if (is_read) begin
                bus_addr <= addr;
              end
            end
          end
          ST_WDATA: begin
            if (rx_fire) begin
              bus_we    <= 1'b1;
              bus_wdata <= rx_data;
              bus_addr  <= addr;
              addr      <= addr + 1'b1;
              len       <= len - 8'd1;
            end
          end
          ST_RD_WAIT: begin
            tx_data  <= bus_rdata;
            tx_valid <= 1'b1;
          end
          ST_RD_PUSH: begin
            if (tx_fire) begin
              tx_valid <= 1'b0;
              addr     <= addr + 1'b1;
              bus_addr <= addr + 1'b1;
              len      <= len - 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
